// File: rtl/eth_arp_sched_pkg.sv
// Shared constants and types for the multi-target ARP resolver / TX scheduler.
// Imported as eth_pkg by eth_arp_sched and its sub-modules.
package eth_pkg;

    localparam logic [3:0] PKT_NONE     = 4'd0;
    localparam logic [3:0] PKT_ARP_REQ  = 4'd1;
    localparam logic [3:0] PKT_ARP_RESP = 4'd2;
    localparam logic [3:0] PKT_UDP      = 4'd3;

    localparam logic [1:0] ARP_OP_NONE  = 2'd0;
    localparam logic [1:0] ARP_OP_REQ   = 2'd1;
    localparam logic [1:0] ARP_OP_REPLY = 2'd2;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    localparam int RESP_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [47:0] mac;
        logic [31:0] ip;
    } arp_peer_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_arp_sched_if.sv
// Handshake bundle between eth_recv/eth_send and eth_arp_sched.
// master = the scheduler, slave = the surrounding receive/send logic.
interface eth_arp_sched_if #(
    parameter int NUM_TARGETS = 2,
    parameter int IDX_W       = 3
);
    logic [1:0]             i_arp_op;
    logic [47:0]            i_arp_mac;
    logic [31:0]            i_arp_ip;
    logic                   i_udp_pend;
    logic                   i_tx_sop;
    logic                   i_tx_eop;
    logic [3:0]             o_pkt_type;
    logic [47:0]            o_target_mac;
    logic [31:0]            o_target_ip;
    logic [IDX_W-1:0]       o_target_idx;
    logic [NUM_TARGETS-1:0] o_resolved;

    modport master (
        input  i_arp_op, i_arp_mac, i_arp_ip, i_udp_pend, i_tx_sop, i_tx_eop,
        output o_pkt_type, o_target_mac, o_target_ip, o_target_idx, o_resolved
    );

    modport slave (
        output i_arp_op, i_arp_mac, i_arp_ip, i_udp_pend, i_tx_sop, i_tx_eop,
        input  o_pkt_type, o_target_mac, o_target_ip, o_target_idx, o_resolved
    );
endinterface

// File: rtl/eth_arp_sched_arp_cache_entry.sv
// One ARP cache slot: resolved MAC, refresh-due flag and reply timeout tracking.
module arp_cache_entry
    import eth_pkg::*;
#(
    parameter int ARP_TIMEOUT_MS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ms_tick,
    input  logic        period_wrap,
    input  logic        reply_hit,
    input  logic [47:0] reply_mac,
    input  logic        req_sent,
    output logic        valid,
    output logic [47:0] mac,
    output logic        req_due
);
    localparam int WAIT_W = cnt_width(ARP_TIMEOUT_MS + 1);

    logic              waiting;
    logic [WAIT_W-1:0] wait_ms;

    // A period wrap re-arms the request even if it is being sent this very cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_due <= 1'b1;
        end else if (period_wrap) begin
            req_due <= 1'b1;
        end else if (req_sent) begin
            req_due <= 1'b0;
        end
    end

    // A matching reply takes precedence over the timeout firing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            mac     <= '0;
            waiting <= 1'b0;
            wait_ms <= '0;
        end else if (reply_hit) begin
            mac     <= reply_mac;
            valid   <= 1'b1;
            waiting <= 1'b0;
            wait_ms <= '0;
        end else if (req_sent) begin
            waiting <= 1'b1;
            wait_ms <= '0;
        end else if (waiting && ms_tick) begin
            if (wait_ms == WAIT_W'(ARP_TIMEOUT_MS - 1)) begin
                valid   <= 1'b0;
                waiting <= 1'b0;
                wait_ms <= '0;
            end else begin
                wait_ms <= wait_ms + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_arp_sched.sv
// Multi-target ARP cache and TX packet-type scheduler (ARP_RESP > ARP_REQ > round-robin UDP).
// Build option ETH_ARP_RESP_FIFO_EN: the ARP response slot becomes a 4-deep FIFO.
module eth_arp_sched
    import eth_pkg::*;
#(
    parameter int NUM_TARGETS    = 2,
    parameter int IDX_W          = 3,
    parameter int TICKS_PER_MS   = 100000,
    parameter int ARP_PERIOD_MS  = 3000,
    parameter int ARP_TIMEOUT_MS = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [32*NUM_TARGETS-1:0] i_target_ip,
    eth_arp_sched_if.master           bus
);
    localparam int PRE_W = cnt_width(TICKS_PER_MS);
    localparam int PER_W = cnt_width(ARP_PERIOD_MS);

    logic [PRE_W-1:0]       presc;
    logic [PER_W-1:0]       period_cnt;
    logic                   ms_tick;
    logic                   period_wrap;

    logic [3:0]             pkt_type_q;
    logic [47:0]            mac_q;
    logic [31:0]            ip_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       rr_ptr;
    logic                   idle_q;
    logic                   sel_en;
    logic                   sop_req;
    logic                   sop_resp;
    logic                   sop_udp;

    logic [NUM_TARGETS-1:0] valid;
    logic [NUM_TARGETS-1:0] req_due;
    logic [NUM_TARGETS-1:0] reply_hit;
    logic [NUM_TARGETS-1:0] req_sent;
    logic [47:0]            ent_mac [NUM_TARGETS];
    logic [31:0]            tgt_ip  [NUM_TARGETS];

    logic                   resp_pend;
    arp_peer_t              resp_peer;
    logic                   arp_req_in;

    logic [3:0]             nxt_type;
    logic [47:0]            nxt_mac;
    logic [31:0]            nxt_ip;
    logic [IDX_W-1:0]       nxt_idx;
    logic                   req_found;
    logic                   udp_found;
    int                     req_sel;
    int                     udp_sel;
    int                     j;

    assign ms_tick     = (presc == PRE_W'(TICKS_PER_MS - 1));
    assign period_wrap = ms_tick && (period_cnt == PER_W'(ARP_PERIOD_MS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            period_cnt <= '0;
        end else begin
            presc <= ms_tick ? '0 : presc + 1'b1;
            if (ms_tick) begin
                period_cnt <= period_wrap ? '0 : period_cnt + 1'b1;
            end
        end
    end

    // Accounting follows whatever packet type eth_send accepted on this sop.
    assign sop_req    = bus.i_tx_sop && (pkt_type_q == PKT_ARP_REQ);
    assign sop_resp   = bus.i_tx_sop && (pkt_type_q == PKT_ARP_RESP);
    assign sop_udp    = bus.i_tx_sop && (pkt_type_q == PKT_UDP);
    assign arp_req_in = (bus.i_arp_op == ARP_OP_REQ);

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_entry
        assign tgt_ip[g]    = i_target_ip[32*g +: 32];
        assign reply_hit[g] = (bus.i_arp_op == ARP_OP_REPLY) && (bus.i_arp_ip == i_target_ip[32*g +: 32]);
        assign req_sent[g]  = sop_req && (idx_q == IDX_W'(g));

        arp_cache_entry #(
            .ARP_TIMEOUT_MS(ARP_TIMEOUT_MS)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .ms_tick    (ms_tick),
            .period_wrap(period_wrap),
            .reply_hit  (reply_hit[g]),
            .reply_mac  (bus.i_arp_mac),
            .req_sent   (req_sent[g]),
            .valid      (valid[g]),
            .mac        (ent_mac[g]),
            .req_due    (req_due[g])
        );
    end

`ifdef ETH_ARP_RESP_FIFO_EN
    localparam int FIFO_AW = $clog2(RESP_FIFO_DEPTH);
    localparam int FIFO_CW = FIFO_AW + 1;

    arp_peer_t            fifo_mem [RESP_FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_CW-1:0]   fifo_cnt;
    logic                 fifo_pop;
    logic                 fifo_push;

    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign fifo_pop  = sop_resp && (fifo_cnt != '0);
    assign fifo_push = arp_req_in && ((fifo_cnt != FIFO_CW'(RESP_FIFO_DEPTH)) || fifo_pop);

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= '{mac: bus.i_arp_mac, ip: bus.i_arp_ip};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + FIFO_CW'(fifo_push) - FIFO_CW'(fifo_pop);
        end
    end

    assign resp_pend = (fifo_cnt != '0);
    assign resp_peer = fifo_mem[rd_ptr];
`else
    arp_peer_t resp_slot;
    logic      resp_pend_q;

    // A fresh request overwrites the slot and keeps it pending even across a response sop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_slot   <= '0;
            resp_pend_q <= 1'b0;
        end else if (arp_req_in) begin
            resp_slot   <= '{mac: bus.i_arp_mac, ip: bus.i_arp_ip};
            resp_pend_q <= 1'b1;
        end else if (sop_resp) begin
            resp_pend_q <= 1'b0;
        end
    end

    assign resp_pend = resp_pend_q;
    assign resp_peer = resp_slot;
`endif

    // Reverse scans leave the lowest due index and the first valid index at or after rr_ptr.
    always_comb begin
        req_found = 1'b0;
        req_sel   = 0;
        udp_found = 1'b0;
        udp_sel   = 0;
        j         = 0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (req_due[i]) begin
                req_found = 1'b1;
                req_sel   = i;
            end
        end
        for (int k = NUM_TARGETS - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NUM_TARGETS;
            if (valid[j]) begin
                udp_found = 1'b1;
                udp_sel   = j;
            end
        end

        nxt_type = PKT_NONE;
        nxt_mac  = mac_q;
        nxt_ip   = ip_q;
        nxt_idx  = idx_q;
        if (resp_pend) begin
            nxt_type = PKT_ARP_RESP;
            nxt_mac  = resp_peer.mac;
            nxt_ip   = resp_peer.ip;
            nxt_idx  = '0;
        end else if (req_found) begin
            nxt_type = PKT_ARP_REQ;
            nxt_mac  = valid[req_sel] ? ent_mac[req_sel] : BCAST_MAC;
            nxt_ip   = tgt_ip[req_sel];
            nxt_idx  = IDX_W'(req_sel);
        end else if (bus.i_udp_pend && udp_found) begin
            nxt_type = PKT_UDP;
            nxt_mac  = ent_mac[udp_sel];
            nxt_ip   = tgt_ip[udp_sel];
            nxt_idx  = IDX_W'(udp_sel);
        end
    end

    // Selection freezes on the sop cycle so accounting and the next choice never race.
    assign sel_en = idle_q && !bus.i_tx_sop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_type_q <= PKT_NONE;
            mac_q      <= BCAST_MAC;
            ip_q       <= '0;
            idx_q      <= '0;
        end else if (sel_en) begin
            pkt_type_q <= nxt_type;
            mac_q      <= nxt_mac;
            ip_q       <= nxt_ip;
            idx_q      <= nxt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= 1'b1;
            rr_ptr <= '0;
        end else begin
            if (bus.i_tx_eop) begin
                idle_q <= 1'b1;
            end else if (bus.i_tx_sop) begin
                idle_q <= 1'b0;
            end
            if (sop_udp) begin
                rr_ptr <= (idx_q == IDX_W'(NUM_TARGETS - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign bus.o_pkt_type   = pkt_type_q;
    assign bus.o_target_mac = mac_q;
    assign bus.o_target_ip  = ip_q;
    assign bus.o_target_idx = idx_q;
    assign bus.o_resolved   = valid;

endmodule

// File: tb/tb_eth_arp_sched.sv
// Directed self-checking bench for eth_arp_sched (2 targets, 10-cycle ms, 100 ms period, 5 ms timeout).
// Also covers the ETH_ARP_RESP_FIFO_EN build when that macro is defined.
module tb_eth_arp_sched;
    import eth_pkg::*;

    localparam int NT = 2;
    localparam int IW = 3;
    localparam logic [31:0] T0  = 32'h0A00_006F;
    localparam logic [31:0] T1  = 32'h0A00_0070;
    localparam logic [47:0] MA  = 48'h0011_2233_4455;
    localparam logic [47:0] MB  = 48'h6677_8899_AABB;
    localparam logic [47:0] RQM = 48'hAABB_CCDD_EEFF;
    localparam logic [31:0] RQI = 32'h0A00_0005;
    localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [1:0]  NOP = 2'd0;
    localparam logic [1:0]  REQ = 2'd1;
    localparam logic [1:0]  RPL = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [47:0] amac;
        logic [31:0] aip;
        logic        udp;
        logic        sop;
        logic        eop;
        logic [3:0]  e_type;
        logic [2:0]  e_idx;
        logic [47:0] e_mac;
        logic [31:0] e_ip;
        logic [1:0]  e_res;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [32*NT-1:0] target_ip;
    int              checks = 0;
    int              errors = 0;
    vec_t            vecs [$];

    assign target_ip = {T1, T0};

    eth_arp_sched_if #(.NUM_TARGETS(NT), .IDX_W(IW)) bus ();

    eth_arp_sched #(
        .NUM_TARGETS   (NT),
        .IDX_W         (IW),
        .TICKS_PER_MS  (10),
        .ARP_PERIOD_MS (100),
        .ARP_TIMEOUT_MS(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_target_ip(target_ip),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] op, input logic [47:0] am, input logic [31:0] ai,
                                input logic u, input logic s, input logic e,
                                input logic [3:0] t, input logic [2:0] x, input logic [47:0] m,
                                input logic [31:0] ip, input logic [1:0] rs);
        vec_t v;
        v.op = op; v.amac = am; v.aip = ai; v.udp = u; v.sop = s; v.eop = e;
        v.e_type = t; v.e_idx = x; v.e_mac = m; v.e_ip = ip; v.e_res = rs;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [47:0] am, input logic [31:0] ai,
                                 input logic u, input logic s, input logic e);
        bus.i_arp_op   = op;
        bus.i_arp_mac  = am;
        bus.i_arp_ip   = ai;
        bus.i_udp_pend = u;
        bus.i_tx_sop   = s;
        bus.i_tx_eop   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic u);
        applyStimulus(NOP, '0, '0, u, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] t, input logic [2:0] x,
                               input logic [47:0] m, input logic [31:0] ip, input logic [1:0] rs);
        checks++;
        if (bus.o_pkt_type !== t || bus.o_target_idx !== x || bus.o_target_mac !== m ||
            bus.o_target_ip !== ip || bus.o_resolved !== rs) begin
            errors++;
            $display("[TB] FAIL %s: got type=%0d idx=%0d mac=%012h ip=%08h res=%b, want type=%0d idx=%0d mac=%012h ip=%08h res=%b",
                     name, bus.o_pkt_type, bus.o_target_idx, bus.o_target_mac, bus.o_target_ip,
                     bus.o_resolved, t, x, m, ip, rs);
        end
    endtask

    task automatic checkValue(input string name, input bit ok, input int got, input int want);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic waitForType(input logic [3:0] t, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            idleCycle(1'b0);
            n++;
            if (bus.o_pkt_type == t) ok = 1'b1;
        end
    endtask

    initial begin
        int  n;
        bit  ok;

        bus.i_arp_op   = NOP;
        bus.i_arp_mac  = '0;
        bus.i_arp_ip   = '0;
        bus.i_udp_pend = 1'b0;
        bus.i_tx_sop   = 1'b0;
        bus.i_tx_eop   = 1'b0;

        // Cycle-by-cycle vectors: inputs for one edge, outputs expected right after it.
        vecs.push_back(mk(NOP, 0,   0,   0,0,0, PKT_ARP_REQ,  3'd0, BC,  T0,  2'b00));
        vecs.push_back(mk(NOP, 0,   0,   0,1,1, PKT_ARP_REQ,  3'd0, BC,  T0,  2'b00));
        vecs.push_back(mk(NOP, 0,   0,   0,0,0, PKT_ARP_REQ,  3'd1, BC,  T1,  2'b00));
        vecs.push_back(mk(NOP, 0,   0,   0,1,0, PKT_ARP_REQ,  3'd1, BC,  T1,  2'b00));
        vecs.push_back(mk(NOP, 0,   0,   0,0,1, PKT_ARP_REQ,  3'd1, BC,  T1,  2'b00));
        vecs.push_back(mk(NOP, 0,   0,   0,0,0, PKT_NONE,     3'd1, BC,  T1,  2'b00));
        vecs.push_back(mk(NOP, 0,   0,   0,1,1, PKT_NONE,     3'd1, BC,  T1,  2'b00));
        vecs.push_back(mk(NOP, 0,   0,   0,0,0, PKT_NONE,     3'd1, BC,  T1,  2'b00));
        vecs.push_back(mk(RPL, MA,  T0,  0,0,0, PKT_NONE,     3'd1, BC,  T1,  2'b01));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_UDP,      3'd0, MA,  T0,  2'b01));
        vecs.push_back(mk(NOP, 0,   0,   1,1,0, PKT_UDP,      3'd0, MA,  T0,  2'b01));
        vecs.push_back(mk(NOP, 0,   0,   1,0,1, PKT_UDP,      3'd0, MA,  T0,  2'b01));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_UDP,      3'd0, MA,  T0,  2'b01));
        vecs.push_back(mk(NOP, 0,   0,   1,1,1, PKT_UDP,      3'd0, MA,  T0,  2'b01));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_UDP,      3'd0, MA,  T0,  2'b01));
        vecs.push_back(mk(RPL, MB,  T1,  1,0,0, PKT_UDP,      3'd0, MA,  T0,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_UDP,      3'd1, MB,  T1,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,1,1, PKT_UDP,      3'd1, MB,  T1,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_UDP,      3'd0, MA,  T0,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,1,1, PKT_UDP,      3'd0, MA,  T0,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_UDP,      3'd1, MB,  T1,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,1,1, PKT_UDP,      3'd1, MB,  T1,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_UDP,      3'd0, MA,  T0,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,1,0, PKT_UDP,      3'd0, MA,  T0,  2'b11));
        vecs.push_back(mk(REQ, RQM, RQI, 1,0,0, PKT_UDP,      3'd0, MA,  T0,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,0,1, PKT_UDP,      3'd0, MA,  T0,  2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_ARP_RESP, 3'd0, RQM, RQI, 2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,1,1, PKT_ARP_RESP, 3'd0, RQM, RQI, 2'b11));
        vecs.push_back(mk(NOP, 0,   0,   1,0,0, PKT_UDP,      3'd1, MB,  T1,  2'b11));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_values", PKT_NONE, 3'd0, BC, 32'd0, 2'b00);
        rst = 1'b0;

        for (int r = 0; r < vecs.size(); r++) begin
            applyStimulus(vecs[r].op, vecs[r].amac, vecs[r].aip, vecs[r].udp, vecs[r].sop, vecs[r].eop);
            checkOutput($sformatf("vec%0d", r), vecs[r].e_type, vecs[r].e_idx, vecs[r].e_mac,
                        vecs[r].e_ip, vecs[r].e_res);
        end

        // UDP idx1 is on the bus; accept it and queue requests while the sender is busy.
        applyStimulus(NOP, '0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("busy_hold", PKT_UDP, 3'd1, MB, T1, 2'b11);
`ifdef ETH_ARP_RESP_FIFO_EN
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(REQ, 48'h0200_0000_0000 + 48'(i), 32'h0A00_0020 + 32'(i), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(NOP, '0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            idleCycle(1'b1);
            checkOutput($sformatf("fifo_resp%0d", i), PKT_ARP_RESP, 3'd0,
                        48'h0200_0000_0000 + 48'(i), 32'h0A00_0020 + 32'(i), 2'b11);
            applyStimulus(NOP, '0, '0, 1'b1, 1'b1, 1'b1);
        end
        idleCycle(1'b1);
        checkOutput("fifo_drop_5th", PKT_UDP, 3'd0, MA, T0, 2'b11);
`else
        applyStimulus(REQ, 48'h0200_0000_0001, 32'h0A00_0021, 1'b1, 1'b0, 1'b0);
        applyStimulus(REQ, 48'h0200_0000_0002, 32'h0A00_0022, 1'b1, 1'b0, 1'b0);
        applyStimulus(NOP, '0, '0, 1'b1, 1'b0, 1'b1);
        idleCycle(1'b1);
        checkOutput("resp_overwrite", PKT_ARP_RESP, 3'd0, 48'h0200_0000_0002, 32'h0A00_0022, 2'b11);
        applyStimulus(REQ, 48'h0200_0000_0003, 32'h0A00_0023, 1'b1, 1'b1, 1'b1);
        checkOutput("resp_sop_hold", PKT_ARP_RESP, 3'd0, 48'h0200_0000_0002, 32'h0A00_0022, 2'b11);
        idleCycle(1'b1);
        checkOutput("resp_req_same_sop", PKT_ARP_RESP, 3'd0, 48'h0200_0000_0003, 32'h0A00_0023, 2'b11);
        applyStimulus(NOP, '0, '0, 1'b1, 1'b1, 1'b1);
        idleCycle(1'b1);
        checkOutput("udp_after_resp", PKT_UDP, 3'd0, MA, T0, 2'b11);
`endif
        applyStimulus(NOP, '0, '0, 1'b0, 1'b1, 1'b1);
        idleCycle(1'b0);
        checkOutput("none_keeps_dest", PKT_NONE, 3'd0, MA, T0, 2'b11);

        // Period refresh: cached MACs are used as unicast targets.
        waitForType(PKT_ARP_REQ, 1200, n, ok);
        checkValue("period1_req_seen", ok, n, 1200);
        checkOutput("refresh_req0", PKT_ARP_REQ, 3'd0, MA, T0, 2'b11);
        applyStimulus(NOP, '0, '0, 1'b0, 1'b1, 1'b1);
        idleCycle(1'b0);
        checkOutput("refresh_req1", PKT_ARP_REQ, 3'd1, MB, T1, 2'b11);
        applyStimulus(NOP, '0, '0, 1'b0, 1'b1, 1'b1);

        // No replies: entry 1 must invalidate five ms ticks after its request sop.
        n  = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            idleCycle(1'b0);
            n++;
            if (bus.o_resolved[1] == 1'b0) ok = 1'b1;
        end
        checkValue("timeout_window", ok && n >= 41 && n <= 50, n, 45);
        checkOutput("after_timeout", PKT_NONE, 3'd1, MB, T1, 2'b00);

        waitForType(PKT_ARP_REQ, 1200, n, ok);
        checkValue("period2_req_seen", ok, n, 1200);
        checkOutput("bcast_req0", PKT_ARP_REQ, 3'd0, BC, T0, 2'b00);
        applyStimulus(NOP, '0, '0, 1'b0, 1'b1, 1'b1);
        idleCycle(1'b0);
        checkOutput("bcast_req1", PKT_ARP_REQ, 3'd1, BC, T1, 2'b00);

        // Reset in the middle of a packet.
        applyStimulus(RPL, MA, T0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midop_reset", PKT_NONE, 3'd0, BC, 32'd0, 2'b00);
        idleCycle(1'b0);
        rst = 1'b0;
        idleCycle(1'b0);
        checkOutput("post_reset_req0", PKT_ARP_REQ, 3'd0, BC, T0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_arp_sched.md
Name: eth_arp_sched

Overview:
- Multi-target ARP resolver and TX packet-type scheduler for the UDP streaming path, sitting between eth_recv (ARP results) and eth_send (packet type and destination).
- Generalises the single-target ARP/UDP selection logic to NUM_TARGETS destination IPs.
- Each target has its own ARP cache entry, refresh and timeout. UDP traffic is round-robined across resolved targets, with priority arbitration against pending ARP responses and requests.

Parameters:
- NUM_TARGETS, 2, number of destination IPs (1..8).
- IDX_W, 3, width of target index (>= clog2(NUM_TARGETS), min 1).
- TICKS_PER_MS, 100000, clk cycles per millisecond tick.
- ARP_PERIOD_MS, 3000, ARP request refresh period per target.
- ARP_TIMEOUT_MS, 1000, maximum wait for a reply before the entry is invalidated.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous active-high reset
- i_target_ip  in  32*NUM_TARGETS  target IPs; target i at bits [32i+31:32i]; static
- i_arp_op  in  2  one-cycle strobe from eth_recv: 1=ARP request received, 2=ARP reply received, 0=none
- i_arp_mac  in  48  sender MAC accompanying i_arp_op
- i_arp_ip  in  32  sender IP accompanying i_arp_op
- i_udp_pend  in  1  UDP payload ready to send
- i_tx_sop  in  1  eth_send start-of-packet (accepted beat)
- i_tx_eop  in  1  eth_send end-of-packet (accepted beat)
- o_pkt_type  out  4  0=NONE, 1=ARP_REQ, 2=ARP_RESP, 3=UDP
- o_target_mac  out  48  destination MAC for the selected packet
- o_target_ip  out  32  destination IP for the selected packet
- o_target_idx  out  IDX_W  target index (ARP_REQ/UDP); 0 for ARP_RESP
- o_resolved  out  NUM_TARGETS  per-target cache-valid flags

Behaviour:
- Reset values:
  - o_pkt_type=0, o_target_mac=48'hFFFFFFFFFFFF, o_target_ip=0, o_target_idx=0, o_resolved=0.
  - All req_due=1, waiting=0, ages=0.
  - Prescaler=0, period counter=0, sender idle=1.
- Tick: prescaler counts 0..TICKS_PER_MS-1; ms_tick pulses for 1 cycle on wrap.
- Period counter: counts ms_tick up to ARP_PERIOD_MS-1. On wrap, sets req_due for every target.
- Per-target entry state: valid, mac[47:0], waiting, wait_ms counter, req_due.
- ARP reply (i_arp_op=2):
  - Compared against every i_target_ip. On match for target i: mac<=i_arp_mac, valid<=1, waiting<=0, wait_ms<=0.
  - A non-matching reply is ignored.
- Timeout: while waiting, wait_ms increments on ms_tick. When it reaches ARP_TIMEOUT_MS: valid<=0, waiting<=0. A reply in the same cycle wins.
- ARP request received (i_arp_op=1): latch {i_arp_mac, i_arp_ip} into the response slot and set resp_pend.
  - A second request before the response is sent overwrites the slot (macro off).
- Sender idle flag: cleared on i_tx_sop, set on i_tx_eop. When both are asserted in the same cycle, eop wins (idle=1).
- Selection: registered, 1-cycle latency, evaluated every cycle while idle. Outputs hold while busy. Priority order:
  1. resp_pend -> ARP_RESP to the latched MAC/IP.
  2. Lowest-index target with req_due -> ARP_REQ. o_target_mac = cached mac if valid, else broadcast.
  3. i_udp_pend and any valid target -> UDP to the first valid target at or after rr_ptr (wrap-around).
  4. Otherwise NONE, with mac/ip unchanged.
- Accounting on i_tx_sop, keyed on the registered o_pkt_type/o_target_idx:
  - ARP_RESP: clear resp_pend.
  - ARP_REQ: req_due[idx]<=0, waiting[idx]<=1, wait_ms<=0. If a period wrap occurs in the same cycle, req_due stays 1.
  - UDP: rr_ptr <= idx+1, wrapping to 0 at NUM_TARGETS.
  - If a new ARP request arrives on the same cycle as sop of an ARP_RESP, resp_pend stays 1.
- A sop with o_pkt_type=NONE is ignored.
- Mid-operation reset returns everything to the reset values. The first post-reset idle cycle selects ARP_REQ for target 0, broadcast.

Optional Feature:
- Macro ETH_ARP_RESP_FIFO_EN.
- Defined: the response slot becomes a 4-entry FIFO of {mac, ip}. resp_pend = !empty; each ARP_RESP sop pops one entry. A push when full is dropped. Push and pop in the same cycle are both honoured.
- Undefined: single slot with overwrite, as above.

Decomposition:
- Package eth_pkg holds:
  - Packet-type constants PKT_NONE/PKT_ARP_REQ/PKT_ARP_RESP/PKT_UDP.
  - ARP op codes ARP_OP_REQ=1 and ARP_OP_REPLY=2.
  - BCAST_MAC.
- Sub-module arp_cache_entry (one instance per target via generate): valid/mac/waiting/wait_ms/req_due, with reply-match, timeout and sop-clear inputs.

Test Plan:
1. Reset, idle, no replies -> cycle 1: o_pkt_type=1, idx=0, mac=FFFFFFFFFFFF, ip=10.0.0.111. After sop/eop -> ARP_REQ idx=1, then NONE.
2. Reply op=2 from 10.0.0.111 with MAC 00:11:22:33:44:55, then i_udp_pend=1 -> o_resolved=01; UDP idx=0 with that MAC, repeated after each eop.
3. Both targets resolved, i_udp_pend held, 4 packets -> idx sequence 0,1,0,1.
4. ARP request op=1 arrives mid-UDP packet -> after eop: ARP_RESP to requester MAC/IP before any further UDP.
5. Request sent, no reply; TICKS_PER_MS=10, ARP_TIMEOUT_MS=5 -> o_resolved[i] falls 50 ticks after sop. The next period gives a broadcast ARP_REQ.
6. ETH_ARP_RESP_FIFO_EN: 5 back-to-back requests while busy -> exactly 4 ARP_RESP packets in arrival order; the 5th is dropped.
